// File: rtl/uart_apb_arbiter.sv
// Two-requester APB arbiter in front of the UART controller's APB slave port.
// Round-robin grant, one downstream transfer per request, optional ACCESS timeout.
module uart_apb_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_PSEL,
  input  logic [1:0]  s_PENABLE,
  input  logic [1:0]  s_PWRITE,
  input  logic [7:0]  s_PADDR,
  input  logic [63:0] s_PWDATA,
  output logic [1:0]  s_PREADY,
  output logic [1:0]  s_PSLVERR,
  output logic [31:0] s_PRDATA,
  output logic        m_PSEL,
  output logic        m_PENABLE,
  output logic        m_PWRITE,
  output logic [3:0]  m_PADDR,
  output logic [31:0] m_PWDATA,
  input  logic        m_PREADY,
  input  logic [31:0] m_PRDATA
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TO_LAST = TIMEOUT - CW'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nx;
  logic          grant, grant_nx;
  logic          last_g, last_g_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  logic          psel_nx, penable_nx, pwrite_nx;
  logic [AW-1:0] paddr_nx;
  logic [DW-1:0] pwdata_nx;
  logic          win;
  logic          timeout_hit;

  // Grant is decided on PSEL alone, so the requesters' enable phase carries no information here.
  logic unused_penable;
  assign unused_penable = ^s_PENABLE;

  // State and registered downstream APB signals
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last_g    <= 1'b1;
      wait_cnt  <= '0;
      m_PSEL    <= 1'b0;
      m_PENABLE <= 1'b0;
      m_PWRITE  <= 1'b0;
      m_PADDR   <= '0;
      m_PWDATA  <= '0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      last_g    <= last_g_nx;
      wait_cnt  <= wait_cnt_nx;
      m_PSEL    <= psel_nx;
      m_PENABLE <= penable_nx;
      m_PWRITE  <= pwrite_nx;
      m_PADDR   <= paddr_nx;
      m_PWDATA  <= pwdata_nx;
    end
  end

  // Next state, arbitration and the combinational requester-side response
  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    last_g_nx   = last_g;
    wait_cnt_nx = wait_cnt;
    psel_nx     = m_PSEL;
    penable_nx  = m_PENABLE;
    pwrite_nx   = m_PWRITE;
    paddr_nx    = m_PADDR;
    pwdata_nx   = m_PWDATA;
    s_PREADY    = '0;
    s_PSLVERR   = '0;
    s_PRDATA    = '0;
    win         = 1'b0;
    timeout_hit = 1'b0;

    unique case (state)
      IDLE: begin
        if (|s_PSEL) begin
          // On a tie the requester not served last wins
          win       = (&s_PSEL) ? ~last_g : s_PSEL[1];
          grant_nx  = win;
          pwrite_nx = s_PWRITE[win];
          paddr_nx  = win ? s_PADDR[AW +: AW] : s_PADDR[0 +: AW];
          pwdata_nx = win ? s_PWDATA[DW +: DW] : s_PWDATA[0 +: DW];
          psel_nx   = 1'b1;
          state_nx  = SETUP;
        end
      end
      SETUP: begin
        penable_nx  = 1'b1;
        wait_cnt_nx = '0;
        state_nx    = ACCESS;
      end
      ACCESS: begin
        timeout_hit      = (TIMEOUT != '0) && !m_PREADY && (wait_cnt == TO_LAST);
        s_PREADY[grant]  = m_PREADY | timeout_hit;
        s_PSLVERR[grant] = timeout_hit;
        s_PRDATA         = timeout_hit ? '0 : m_PRDATA;
        if (m_PREADY || timeout_hit) begin
          last_g_nx  = grant;
          psel_nx    = 1'b0;
          penable_nx = 1'b0;
          state_nx   = IDLE;
        end else if (wait_cnt != '1) begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Directed bench for uart_apb_arbiter: a cycle table for the arbitration/data paths
// plus hand-written sequences for timeout, long wait states and mid-transfer reset.
module tb_uart_apb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  s_PSEL, s_PENABLE, s_PWRITE;
  logic [7:0]  s_PADDR;
  logic [63:0] s_PWDATA;
  logic        m_PREADY;
  logic [31:0] m_PRDATA;

  logic [1:0]  s_PREADY, s_PSLVERR, s_PREADY_t, s_PSLVERR_t;
  logic [31:0] s_PRDATA, s_PRDATA_t;
  logic        m_PSEL, m_PENABLE, m_PWRITE, m_PSEL_t, m_PENABLE_t, m_PWRITE_t;
  logic [3:0]  m_PADDR, m_PADDR_t;
  logic [31:0] m_PWDATA, m_PWDATA_t;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_apb_arbiter #(.TIMEOUT(16'd0)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
    .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA),
    .s_PREADY(s_PREADY), .s_PSLVERR(s_PSLVERR), .s_PRDATA(s_PRDATA),
    .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE), .m_PWRITE(m_PWRITE),
    .m_PADDR(m_PADDR), .m_PWDATA(m_PWDATA),
    .m_PREADY(m_PREADY), .m_PRDATA(m_PRDATA)
  );

  uart_apb_arbiter #(.TIMEOUT(16'd8)) u_dut_to (
    .clk(clk), .reset_n(reset_n),
    .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
    .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA),
    .s_PREADY(s_PREADY_t), .s_PSLVERR(s_PSLVERR_t), .s_PRDATA(s_PRDATA_t),
    .m_PSEL(m_PSEL_t), .m_PENABLE(m_PENABLE_t), .m_PWRITE(m_PWRITE_t),
    .m_PADDR(m_PADDR_t), .m_PWDATA(m_PWDATA_t),
    .m_PREADY(m_PREADY), .m_PRDATA(m_PRDATA)
  );

  typedef struct {
    logic [1:0]  psel;
    logic [1:0]  pwrite;
    logic [7:0]  paddr;
    logic [63:0] pwdata;
    logic        mrdy;
    logic [31:0] mrdata;
    logic        e_msel;
    logic        e_men;
    logic        e_mwr;
    logic [3:0]  e_maddr;
    logic [31:0] e_mwdata;
    logic [1:0]  e_srdy;
    logic [31:0] e_srdata;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [1:0] psel, input logic [1:0] pwrite,
                              input logic [7:0] paddr, input logic [63:0] pwdata,
                              input logic mrdy, input logic [31:0] mrdata,
                              input logic e_msel, input logic e_men, input logic e_mwr,
                              input logic [3:0] e_maddr, input logic [31:0] e_mwdata,
                              input logic [1:0] e_srdy, input logic [31:0] e_srdata);
    vec_t v;
    v.psel = psel;     v.pwrite = pwrite;   v.paddr = paddr;     v.pwdata = pwdata;
    v.mrdy = mrdy;     v.mrdata = mrdata;   v.e_msel = e_msel;   v.e_men = e_men;
    v.e_mwr = e_mwr;   v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_srdy = e_srdy; v.e_srdata = e_srdata;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] psel, input logic [1:0] pwrite, input logic [7:0] paddr,
                       input logic [63:0] pwdata, input logic mrdy, input logic [31:0] mrdata);
    s_PSEL = psel; s_PENABLE = psel; s_PWRITE = pwrite; s_PADDR = paddr;
    s_PWDATA = pwdata; m_PREADY = mrdy; m_PRDATA = mrdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(2'b00, 2'b00, 8'h00, 64'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk("rst_msel",    64'(m_PSEL),    64'h0);
    chk("rst_men",     64'(m_PENABLE), 64'h0);
    chk("rst_mwrite",  64'(m_PWRITE),  64'h0);
    chk("rst_maddr",   64'(m_PADDR),   64'h0);
    chk("rst_mwdata",  64'(m_PWDATA),  64'h0);
    chk("rst_sready",  64'(s_PREADY),  64'h0);
    chk("rst_slverr",  64'(s_PSLVERR), 64'h0);
    chk("rst_srdata",  64'(s_PRDATA),  64'h0);
    chk("rst_msel_t",  64'(m_PSEL_t),  64'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(2'b00, 2'b00, 8'h00, 64'h0, 1'b0, 32'h0);

    // Both requesters keep requesting: grants alternate 0, 1, then 0 again
    add(2'b11, 2'b11, 8'h21, {32'hB1, 32'hA0}, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0,  2'b00, 32'h0);
    add(2'b11, 2'b11, 8'h21, {32'hB1, 32'hA0}, 1'b1, 32'h0, 1, 0, 1, 4'h1, 32'hA0, 2'b00, 32'h0);
    add(2'b11, 2'b11, 8'h21, {32'hB1, 32'hA0}, 1'b1, 32'h5, 1, 1, 1, 4'h1, 32'hA0, 2'b01, 32'h5);
    add(2'b11, 2'b11, 8'h23, {32'hB1, 32'hA2}, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0,  2'b00, 32'h0);
    add(2'b11, 2'b11, 8'h23, {32'hB1, 32'hA2}, 1'b1, 32'h0, 1, 0, 1, 4'h2, 32'hB1, 2'b00, 32'h0);
    add(2'b11, 2'b11, 8'h23, {32'hB1, 32'hA2}, 1'b1, 32'h0, 1, 1, 1, 4'h2, 32'hB1, 2'b10, 32'h0);
    add(2'b01, 2'b11, 8'h23, {32'hB1, 32'hA2}, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0,  2'b00, 32'h0);
    add(2'b01, 2'b11, 8'h23, {32'hB1, 32'hA2}, 1'b1, 32'h0, 1, 0, 1, 4'h3, 32'hA2, 2'b00, 32'h0);
    add(2'b01, 2'b11, 8'h23, {32'hB1, 32'hA2}, 1'b1, 32'h0, 1, 1, 1, 4'h3, 32'hA2, 2'b01, 32'h0);
    // Requester 1 reads address 0; read data must not leak outside ACCESS
    add(2'b10, 2'b00, 8'h00, 64'h0, 1'b1, 32'h155, 0, 0, 0, 4'h0, 32'h0, 2'b00, 32'h0);
    add(2'b10, 2'b00, 8'h00, 64'h0, 1'b1, 32'h155, 1, 0, 0, 4'h0, 32'h0, 2'b00, 32'h0);
    add(2'b10, 2'b00, 8'h00, 64'h0, 1'b1, 32'h155, 1, 1, 0, 4'h0, 32'h0, 2'b10, 32'h155);
    // Requester 0 alone writes 0x41 to address 4
    add(2'b01, 2'b01, 8'h04, 64'h41, 1'b1, 32'h0, 0, 0, 0, 4'h0, 32'h0,  2'b00, 32'h0);
    add(2'b01, 2'b01, 8'h04, 64'h41, 1'b1, 32'h0, 1, 0, 1, 4'h4, 32'h41, 2'b00, 32'h0);
    add(2'b01, 2'b01, 8'h04, 64'h41, 1'b1, 32'h0, 1, 1, 1, 4'h4, 32'h41, 2'b01, 32'h0);
    // Requester 0 read with two wait states
    add(2'b01, 2'b00, 8'h05, 64'h0, 1'b0, 32'h77, 0, 0, 0, 4'h0, 32'h0, 2'b00, 32'h0);
    add(2'b01, 2'b00, 8'h05, 64'h0, 1'b0, 32'h77, 1, 0, 0, 4'h5, 32'h0, 2'b00, 32'h0);
    add(2'b01, 2'b00, 8'h05, 64'h0, 1'b0, 32'h77, 1, 1, 0, 4'h5, 32'h0, 2'b00, 32'h77);
    add(2'b01, 2'b00, 8'h05, 64'h0, 1'b0, 32'h78, 1, 1, 0, 4'h5, 32'h0, 2'b00, 32'h78);
    add(2'b01, 2'b00, 8'h05, 64'h0, 1'b1, 32'h99, 1, 1, 0, 4'h5, 32'h0, 2'b01, 32'h99);
    add(2'b00, 2'b00, 8'h00, 64'h0, 1'b0, 32'h0,  0, 0, 0, 4'h0, 32'h0, 2'b00, 32'h0);

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].psel, tbl[i].pwrite, tbl[i].paddr, tbl[i].pwdata, tbl[i].mrdy, tbl[i].mrdata);
      #1;
      chk($sformatf("v%0d_msel", i),   64'(m_PSEL),      64'(tbl[i].e_msel));
      chk($sformatf("v%0d_men", i),    64'(m_PENABLE),   64'(tbl[i].e_men));
      chk($sformatf("v%0d_sready", i), 64'(s_PREADY),    64'(tbl[i].e_srdy));
      chk($sformatf("v%0d_srdata", i), 64'(s_PRDATA),    64'(tbl[i].e_srdata));
      chk($sformatf("v%0d_slverr", i), 64'(s_PSLVERR),   64'h0);
      chk($sformatf("v%0d_sready_t", i), 64'(s_PREADY_t), 64'(tbl[i].e_srdy));
      chk($sformatf("v%0d_msel_t", i), 64'(m_PSEL_t),    64'(tbl[i].e_msel));
      if (tbl[i].e_msel) begin
        chk($sformatf("v%0d_mwrite", i), 64'(m_PWRITE), 64'(tbl[i].e_mwr));
        chk($sformatf("v%0d_maddr", i),  64'(m_PADDR),  64'(tbl[i].e_maddr));
        chk($sformatf("v%0d_mwdata", i), 64'(m_PWDATA), 64'(tbl[i].e_mwdata));
      end
    end

    // Timeout of 8: error response on the 8th ACCESS cycle with zeroed read data
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b01, 8'h07, 64'h33, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to_c%0d_slverr_nto", k), 64'(s_PSLVERR), 64'h0);
      if (k < 8) begin
        chk($sformatf("to_c%0d_rdy", k), 64'(s_PREADY_t),  64'h0);
        chk($sformatf("to_c%0d_err", k), 64'(s_PSLVERR_t), 64'h0);
      end else begin
        chk("to_rdy",   64'(s_PREADY_t),  64'h1);
        chk("to_err",   64'(s_PSLVERR_t), 64'h1);
        chk("to_rdata", 64'(s_PRDATA_t),  64'h0);
      end
    end
    @(negedge clk);
    s_PSEL = 2'b00; s_PENABLE = 2'b00;
    #1;
    chk("to_after_msel", 64'(m_PSEL_t),    64'h0);
    chk("to_after_err",  64'(s_PSLVERR_t), 64'h0);
    chk("to_after_rdy",  64'(s_PREADY_t),  64'h0);

    // No timeout: 100 wait states, completion on the cycle m_PREADY rises
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b01, 8'h03, 64'h80, 1'b0, 32'h0);
    @(negedge clk);
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k == 101) m_PREADY = 1'b1;
      #1;
      if (k < 101) begin
        chk($sformatf("w_c%0d_rdy", k), 64'(s_PREADY),  64'h0);
        chk($sformatf("w_c%0d_err", k), 64'(s_PSLVERR), 64'h0);
      end else begin
        chk("w_done_rdy", 64'(s_PREADY),  64'h1);
        chk("w_done_err", 64'(s_PSLVERR), 64'h0);
        chk("w_done_men", 64'(m_PENABLE), 64'h1);
      end
    end
    @(negedge clk);
    s_PSEL = 2'b00; s_PENABLE = 2'b00; m_PREADY = 1'b0;
    #1;
    chk("w_after_msel", 64'(m_PSEL), 64'h0);

    // Reset pulse during ACCESS aborts at once; the held request is served again from SETUP
    do_reset();
    @(negedge clk);
    drive(2'b10, 2'b10, 8'h90, {32'h99, 32'h0}, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ra_msel_pre", 64'(m_PSEL),    64'h1);
    chk("ra_men_pre",  64'(m_PENABLE), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ra_msel_async", 64'(m_PSEL),    64'h0);
    chk("ra_men_async",  64'(m_PENABLE), 64'h0);
    chk("ra_srdy_async", 64'(s_PREADY),  64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ra_setup_msel",   64'(m_PSEL),    64'h1);
    chk("ra_setup_men",    64'(m_PENABLE), 64'h0);
    chk("ra_setup_maddr",  64'(m_PADDR),   64'h9);
    chk("ra_setup_mwdata", 64'(m_PWDATA),  64'h99);
    @(negedge clk);
    m_PREADY = 1'b1;
    #1;
    chk("ra_done_rdy", 64'(s_PREADY), 64'h2);
    @(negedge clk);
    s_PSEL = 2'b00; s_PENABLE = 2'b00; m_PREADY = 1'b0;
    #1;
    chk("ra_idle_msel", 64'(m_PSEL), 64'h0);
    @(negedge clk);
    #1;
    chk("ra_no_replay", 64'(m_PSEL), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
